// File: rtl/pickup_placer.sv
// Draws an (x,y) placement from a free-running random stream by rejection
// sampling against inclusive bounds, aborting after MAX_TRIES rejections.
module pickup_placer #(
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int MAX_TRIES = 16
) (
  input  logic       Clk,
  input  logic       Reset_h,
  input  logic [9:0] rand_in,
  input  logic       req,
  input  logic       ack,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       valid,
  output logic       busy,
  output logic       fail
);

  typedef enum logic [1:0] {IDLE, GET_X, GET_Y, DONE} state_t;

  localparam logic [9:0] X_BOUND  = 10'(X_MAX);
  localparam logic [9:0] Y_BOUND  = 10'(Y_MAX);
  localparam logic [7:0] TRY_LAST = 8'(MAX_TRIES - 1);

  state_t     state, state_next;
  logic [7:0] tries;
  logic       x_ok, y_ok, at_limit;

  assign x_ok     = (rand_in <= X_BOUND);
  assign y_ok     = (rand_in <= Y_BOUND);
  assign at_limit = (tries == TRY_LAST);

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (req) state_next = GET_X;
      GET_X: if (x_ok) state_next = GET_Y;
             else if (at_limit) state_next = DONE;
      GET_Y: if (y_ok || at_limit) state_next = DONE;
      DONE:  if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == DONE);
    busy  = (state != IDLE);
  end

  // Coordinates, abort flag and retry count; the counter stops at the limit
  // because reaching it always leaves the sampling state.
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      x     <= '0;
      y     <= '0;
      fail  <= 1'b0;
      tries <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          tries <= '0;
          fail  <= 1'b0;
        end
        GET_X: begin
          if (x_ok) begin
            x     <= rand_in;
            tries <= '0;
          end else if (at_limit) begin
            x    <= '0;
            y    <= '0;
            fail <= 1'b1;
          end else begin
            tries <= tries + 8'd1;
          end
        end
        GET_Y: begin
          if (y_ok) begin
            y    <= rand_in;
            fail <= 1'b0;
          end else if (at_limit) begin
            x    <= '0;
            y    <= '0;
            fail <= 1'b1;
          end else begin
            tries <= tries + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
